// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer family: mode encodings and
// the channel-id width helper used to size select and source-id fields.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single-channel mux still needs a 1-bit id field.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer-side and consumer-side stream signals of the N:1 mux.
// The mux uses the slave view; the surrounding environment uses master.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8
);
    localparam int SEL_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;

    modport master (
        output in_valid, in_data, mode, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, mode, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping past NUM_CH-1, found by rotating a doubled request vector.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] win;
    logic [SEL_W:0]    sum;

    // win[i] is the request of channel (ptr + i) mod NUM_CH.
    assign win = NUM_CH'({req, req} >> ptr);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_valid = 1'b0;
        sum       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (win[i]) begin
                gnt_valid = 1'b1;
                sum       = {1'b0, ptr} + (SEL_W+1)'(i);
            end
        end
        gnt_idx = (sum >= NUM_CH_W) ? SEL_W'(sum - NUM_CH_W) : SEL_W'(sum);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with fixed-select and round-robin modes and a
// single registered output stage that also reports the source channel.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = ch_w(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_valid;
    logic              fix_valid;
    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic              load_en;
    logic              take;
    logic [DATA_W-1:0] grant_data;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    always_comb begin
        // An out-of-range select grants nothing rather than aliasing a channel.
        fix_valid = ({1'b0, bus.sel} < NUM_CH_W) && bus.in_valid[bus.sel];
        if (bus.mode == MODE_RR) begin
            grant       = rr_idx;
            grant_valid = rr_valid;
        end else begin
            grant       = bus.sel;
            grant_valid = fix_valid;
        end
        load_en    = !bus.out_valid || bus.out_ready;
        take       = load_en && grant_valid;
        grant_data = bus.in_data[grant*DATA_W +: DATA_W];
    end

    always_comb begin
        bus.in_ready = '0;
        if (take) bus.in_ready[grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data/id fields are reset too, so a drained output reads as zero rather than X after reset.
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else begin
            if (load_en) bus.out_valid <= grant_valid;
            if (take) begin
                bus.out_data <= grant_data;
                bus.out_ch   <= grant;
            end
            if (take && bus.mode == MODE_RR)
                ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: reference model plus beat scoreboard checked
// every cycle, with per-scenario checks inside each test task.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int NCH = 8;
    localparam int DW  = 8;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    stream_mux_rr #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t      sb[$];
    logic       m_full;
    logic [2:0] m_ch;
    logic [7:0] m_data;
    logic [2:0] m_ptr;

    function automatic int rr_model(input logic [7:0] v, input int p);
        for (int i = 0; i < NCH; i++)
            if (v[(p + i) % NCH]) return (p + i) % NCH;
        return -1;
    endfunction

    task automatic set_data(input logic [7:0] base);
        for (int k = 0; k < NCH; k++) bus.in_data[k*DW +: DW] = base + 8'(k);
    endtask

    task automatic reset_model();
        m_full = 1'b0;
        m_ch   = '0;
        m_data = '0;
        m_ptr  = '0;
        sb.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        int         g;
        logic       gv, ld, tk, md;
        logic [7:0] exp_rdy, d;
        beat_t      exp_b;
        @(negedge clk);
        md = bus.mode;
        ld = !m_full || bus.out_ready;
        if (md == MODE_RR) g = rr_model(bus.in_valid, int'(m_ptr));
        else               g = bus.in_valid[bus.sel] ? int'(bus.sel) : -1;
        gv      = (g >= 0);
        tk      = ld && gv;
        exp_rdy = tk ? (8'h01 << g) : 8'h00;
        d       = tk ? bus.in_data[g*DW +: DW] : 8'h00;

        tests_run++;
        if (bus.in_ready !== exp_rdy) begin
            tests_failed++;
            $display("FAIL in_ready: got %b want %b @%0t", bus.in_ready, exp_rdy, $time);
        end
        tests_run++;
        if (bus.out_valid !== m_full) begin
            tests_failed++;
            $display("FAIL out_valid: got %b want %b @%0t", bus.out_valid, m_full, $time);
        end
        tests_run++;
        if ({bus.out_ch, bus.out_data} !== {m_ch, m_data}) begin
            tests_failed++;
            $display("FAIL out_regs: got ch %0d data %h want ch %0d data %h @%0t",
                     bus.out_ch, bus.out_data, m_ch, m_data, $time);
        end
        if (m_full && bus.out_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard: beat delivered with empty queue @%0t", $time);
            end else begin
                exp_b = sb.pop_front();
                if ({bus.out_ch, bus.out_data} !== exp_b) begin
                    tests_failed++;
                    $display("FAIL scoreboard: got ch %0d data %h want ch %0d data %h @%0t",
                             bus.out_ch, bus.out_data, exp_b.ch, exp_b.data, $time);
                end
            end
        end

        @(posedge clk);
        if (ld) m_full = gv;
        if (tk) begin
            m_ch   = 3'(g);
            m_data = d;
            sb.push_back('{ch: 3'(g), data: d});
            if (md == MODE_RR) m_ptr = (g == NCH - 1) ? 3'd0 : 3'(g + 1);
        end
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = '0;
        bus.mode      = MODE_FIXED;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        set_data(8'h00);
        reset_model();
        #2;
        tests_run++;
        if ({bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: valid %b data %h ch %0d rdy %b want all 0",
                     bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        bus.mode     = MODE_FIXED;
        bus.in_valid = 8'hFF;
        set_data(8'h10);
        for (int s = 0; s < NCH; s++) begin
            bus.sel = 3'(s);
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 3'(s), 8'h10 + 8'(s)}) begin
                tests_failed++;
                $display("FAIL fixed_sel%0d: got v %b ch %0d data %h want v 1 ch %0d data %h",
                         s, bus.out_valid, bus.out_ch, bus.out_data, s, 8'h10 + 8'(s));
            end
        end
    endtask

    task automatic test_rr_all();
        bus.mode     = MODE_RR;
        bus.in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_ch} !== {1'b1, 3'(i % NCH)}) begin
                tests_failed++;
                $display("FAIL rr_all_%0d: got v %b ch %0d want v 1 ch %0d",
                         i, bus.out_valid, bus.out_ch, i % NCH);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_seq[7] = '{2, 6, 2, 6, 2, 2, 2};
        apply_reset();
        bus.mode     = MODE_RR;
        bus.in_valid = 8'h44;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) bus.in_valid = 8'h04;
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_ch} !== {1'b1, 3'(exp_seq[i])}) begin
                tests_failed++;
                $display("FAIL rr_sparse_%0d: got v %b ch %0d want v 1 ch %0d",
                         i, bus.out_valid, bus.out_ch, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        beat_t hold;
        bus.mode      = MODE_RR;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        set_data(8'h20);
        repeat (3) tick();
        hold          = '{ch: m_ch, data: m_data};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_data(8'($urandom));
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready} !== {1'b1, hold, 8'h00}) begin
                tests_failed++;
                $display("FAIL stall_%0d: got v %b ch %0d data %h rdy %b want v 1 ch %0d data %h rdy 0",
                         i, bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready, hold.ch, hold.data);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_ch} !== {1'b1, hold.ch + 3'd1}) begin
            tests_failed++;
            $display("FAIL release: got v %b ch %0d want v 1 ch %0d",
                     bus.out_valid, bus.out_ch, hold.ch + 3'd1);
        end
        repeat (3) tick();
    endtask

    task automatic test_fixed_hole();
        int saved_ptr;
        int exp_ch;
        saved_ptr     = int'(m_ptr);
        bus.mode      = MODE_FIXED;
        bus.sel       = 3'd3;
        bus.in_valid  = 8'hF7;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL hole_drain_%0d: got out_valid %b want 0", i, bus.out_valid);
            end
        end
        bus.mode = MODE_RR;
        exp_ch   = rr_model(8'hF7, saved_ptr);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_ch} !== {1'b1, 3'(exp_ch)}) begin
            tests_failed++;
            $display("FAIL hole_resume: got v %b ch %0d want v 1 ch %0d",
                     bus.out_valid, bus.out_ch, exp_ch);
        end
    endtask

    task automatic test_reset_mid();
        bus.mode      = MODE_RR;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        set_data(8'h40);
        repeat (2) tick();
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: got out_valid %b want 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_data, bus.out_ch} !== '0) begin
            tests_failed++;
            $display("FAIL mid_async: got v %b data %h ch %0d want all 0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        bus.in_valid = 8'hB0;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 3'd4, 8'h44}) begin
            tests_failed++;
            $display("FAIL mid_restart: got v %b ch %0d data %h want v 1 ch 4 data 44",
                     bus.out_valid, bus.out_ch, bus.out_data);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_back_to_back();
        test_fixed_hole();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
